// File: rtl/cache2_ctrl.sv
// Controller for a 2-way, write-back, write-allocate, LRU cache with 16-byte blocks.
// It owns the tag, valid, dirty, LRU and data arrays and keeps saturating hit and miss counters.
//
// state     | meaning
// IDLE      | waiting for cpu_req; the request is latched on accept
// LOOKUP    | tag compare; a hit completes the access, a miss picks a victim
// WRITEBACK | dirty victim block being written to memory
// REFILL    | requested block being read from memory into the victim way
// RESP      | one-cycle cpu_ready pulse; the statistics counters update
module cache2_ctrl #(
   parameter int ADDR_W   = 10,
   parameter int NUM_SETS = 2,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_rw,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_hit,
   output logic [31:0]       cpu_rdata,
   output logic              mem_req,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [127:0]      mem_wdata,
   input  logic [127:0]      mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_W - 4 - IDX_W;

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESP} stateT;

   stateT state, stateNext;

   logic [ADDR_W-1:2]  reqAddr;
   logic               reqRw;
   logic [31:0]        reqWdata;
   logic               missed;
   logic               victimWay;

   logic [TAG_W-1:0]   tagArr  [NUM_SETS][2];
   logic [127:0]       dataArr [NUM_SETS][2];
   logic [NUM_SETS-1:0][1:0] validArr;
   logic [NUM_SETS-1:0][1:0] dirtyArr;
   logic [NUM_SETS-1:0]      lruArr;

   logic [TAG_W-1:0]   reqTag;
   logic [IDX_W-1:0]   reqIdx;
   logic [1:0]         reqWord;
   logic               hit0, hit1, anyHit, hitWay;
   logic               victimSel, victimDirty;
   logic [1:0]         unusedAddrBits;

   assign unusedAddrBits = cpu_addr[1:0];

   assign reqTag  = reqAddr[ADDR_W-1 -: TAG_W];
   assign reqIdx  = reqAddr[4 +: IDX_W];
   assign reqWord = reqAddr[3:2];

   assign hit0   = validArr[reqIdx][0] && (tagArr[reqIdx][0] == reqTag);
   assign hit1   = validArr[reqIdx][1] && (tagArr[reqIdx][1] == reqTag);
   assign anyHit = hit0 | hit1;
   assign hitWay = ~hit0;

   // Fill empty ways first, lowest way first; only evict by LRU when the set is full.
   assign victimSel   = !validArr[reqIdx][0] ? 1'b0 :
                        !validArr[reqIdx][1] ? 1'b1 : lruArr[reqIdx];
   assign victimDirty = validArr[reqIdx][victimSel] && dirtyArr[reqIdx][victimSel];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:      if (cpu_req) stateNext = LOOKUP;
         LOOKUP: begin
            if (anyHit)           stateNext = RESP;
            else if (victimDirty) stateNext = WRITEBACK;
            else                  stateNext = REFILL;
         end
         WRITEBACK: if (mem_ack) stateNext = REFILL;
         REFILL:    if (mem_ack) stateNext = LOOKUP;
         RESP:      stateNext = IDLE;
         default:   stateNext = IDLE;
      endcase
   end

   always_comb begin
      cpu_ready = 1'b0;
      cpu_hit   = 1'b0;
      mem_req   = 1'b0;
      mem_rw    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         WRITEBACK: begin
            mem_req   = 1'b1;
            mem_rw    = 1'b1;
            mem_addr  = {tagArr[reqIdx][victimWay], reqIdx, 4'b0000};
            mem_wdata = dataArr[reqIdx][victimWay];
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {reqTag, reqIdx, 4'b0000};
         end
         RESP: begin
            cpu_ready = 1'b1;
            cpu_hit   = ~missed;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reqAddr   <= '0;
         reqRw     <= 1'b0;
         reqWdata  <= '0;
         missed    <= 1'b0;
         victimWay <= 1'b0;
         validArr  <= '0;
         dirtyArr  <= '0;
         lruArr    <= '0;
         cpu_rdata <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         case (state)
            IDLE: if (cpu_req) begin
               reqAddr  <= cpu_addr[ADDR_W-1:2];
               reqRw    <= cpu_rw;
               reqWdata <= cpu_wdata;
               missed   <= 1'b0;
            end
            LOOKUP: begin
               if (anyHit) begin
                  if (reqRw) dirtyArr[reqIdx][hitWay] <= 1'b1;
                  else       cpu_rdata <= dataArr[reqIdx][hitWay][{reqWord, 5'd0} +: 32];
                  lruArr[reqIdx] <= ~hitWay;
               end else begin
                  missed    <= 1'b1;
                  victimWay <= victimSel;
               end
            end
            WRITEBACK: if (mem_ack) dirtyArr[reqIdx][victimWay] <= 1'b0;
            REFILL: if (mem_ack) begin
               validArr[reqIdx][victimWay] <= 1'b1;
               dirtyArr[reqIdx][victimWay] <= 1'b0;
            end
            RESP: begin
               if (!missed) begin
                  if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
               end else begin
                  if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Tag and data arrays carry no reset; writes are still blocked while reset is high.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == LOOKUP && anyHit && reqRw)
            dataArr[reqIdx][hitWay][{reqWord, 5'd0} +: 32] <= reqWdata;
         if (state == REFILL && mem_ack) begin
            dataArr[reqIdx][victimWay] <= mem_rdata;
            tagArr[reqIdx][victimWay]  <= reqTag;
         end
      end
   end
endmodule

// File: tb/tb_cache2_ctrl.sv
// Directed bench for cache2_ctrl: refill, hits, clean and dirty eviction, stalled memory, reset mid-refill.
module tb_cache2_ctrl;
   logic         clk = 1'b0;
   logic         reset;
   logic         cpu_req, cpu_rw;
   logic [9:0]   cpu_addr;
   logic [31:0]  cpu_wdata;
   logic         cpu_ready, cpu_hit;
   logic [31:0]  cpu_rdata;
   logic         mem_req, mem_rw;
   logic [9:0]   mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_ack;
   logic [15:0]  hit_cnt, miss_cnt;

   int total = 0;
   int bad   = 0;

   int           nRd, nWr;
   logic         firstRw, stableBad, readyStuck;
   logic [9:0]   lastRdAddr, lastWrAddr;
   logic [127:0] lastWrData;

   cache2_ctrl #(.ADDR_W(10), .NUM_SETS(2), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
      .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   // Memory contents: word k of block a is 0x11111111*(k+1) + a.
   function automatic logic [127:0] refillData(input logic [9:0] a);
      logic [127:0] r;
      for (int k = 0; k < 4; k++) r[32*k +: 32] = 32'(32'h1111_1111 * (k + 1)) + 32'(a);
      return r;
   endfunction

   task automatic doReq(input logic rw, input logic [9:0] addr, input logic [31:0] wd,
                        input int ackDelay, output logic gotHit, output logic [31:0] gotRdata,
                        output int cyc);
      logic         done;
      logic         holdRw;
      logic [9:0]   holdAddr;
      logic [127:0] holdData;
      nRd = 0; nWr = 0; firstRw = 1'b0; stableBad = 1'b0; readyStuck = 1'b0;
      gotHit = 1'b0; gotRdata = '0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
      @(negedge clk);
      cpu_req = 1'b0;
      cyc = 1; done = 1'b0;
      while (!done && cyc < 300) begin
         if (cpu_ready) begin
            done = 1'b1; gotHit = cpu_hit; gotRdata = cpu_rdata;
         end else if (mem_req) begin
            if (nRd + nWr == 0) firstRw = mem_rw;
            if (mem_rw) begin nWr++; lastWrAddr = mem_addr; lastWrData = mem_wdata; end
            else begin nRd++; lastRdAddr = mem_addr; end
            holdRw = mem_rw; holdAddr = mem_addr; holdData = mem_wdata;
            for (int d = 0; d < ackDelay; d++) begin
               cpu_addr = 10'($urandom); cpu_wdata = $urandom;
               @(negedge clk); cyc++;
               if (mem_req !== 1'b1 || mem_rw !== holdRw || mem_addr !== holdAddr ||
                   mem_wdata !== holdData) stableBad = 1'b1;
            end
            mem_rdata = refillData(mem_addr);
            mem_ack = 1'b1;
            @(negedge clk); cyc++;
            mem_ack = 1'b0;
         end else begin
            @(negedge clk); cyc++;
         end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL req_timeout addr=%h: no cpu_ready within %0d cycles", addr, cyc);
      end else begin
         @(negedge clk);
         readyStuck = cpu_ready;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      total++; if ({cpu_ready, cpu_hit, mem_req, mem_rw} !== 4'b0) begin bad++;
         $display("FAIL reset_ctl got=%b want=0000", {cpu_ready, cpu_hit, mem_req, mem_rw}); end
      total++; if (cpu_rdata !== 32'h0) begin bad++;
         $display("FAIL reset_rdata got=%h want=0", cpu_rdata); end
      total++; if (mem_addr !== 10'h0 || mem_wdata !== 128'h0) begin bad++;
         $display("FAIL reset_mem got=%h/%h want=0", mem_addr, mem_wdata); end
      total++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin bad++;
         $display("FAIL reset_cnt got=%0d/%0d want=0/0", hit_cnt, miss_cnt); end
      reset = 1'b0;
   endtask

   task automatic test_refill_read();
      logic h; logic [31:0] rd; int c;
      doReq(1'b0, 10'h000, 32'h0, 0, h, rd, c);
      total++; if (nRd !== 1 || nWr !== 0 || lastRdAddr !== 10'h000) begin bad++;
         $display("FAIL miss_txn got rd=%0d wr=%0d addr=%h want 1/0/000", nRd, nWr, lastRdAddr); end
      total++; if (h !== 1'b0 || rd !== 32'h1111_1111) begin bad++;
         $display("FAIL miss_resp got hit=%b rdata=%h want 0/11111111", h, rd); end
      total++; if (readyStuck !== 1'b0) begin bad++;
         $display("FAIL ready_pulse got=%b want=0 one cycle after ready", readyStuck); end
      doReq(1'b0, 10'h004, 32'h0, 0, h, rd, c);
      total++; if (c !== 2) begin bad++;
         $display("FAIL hit_latency got=%0d want=2", c); end
      total++; if (h !== 1'b1 || rd !== 32'h2222_2222 || nRd + nWr !== 0) begin bad++;
         $display("FAIL hit_read got hit=%b rdata=%h txns=%0d want 1/22222222/0", h, rd, nRd + nWr); end
      total++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin bad++;
         $display("FAIL cnt_first got=%0d/%0d want=1/1", hit_cnt, miss_cnt); end
   endtask

   task automatic test_write_hit();
      logic h; logic [31:0] rd; int c;
      doReq(1'b1, 10'h008, 32'hDEAD_BEEF, 0, h, rd, c);
      total++; if (h !== 1'b1 || nRd + nWr !== 0) begin bad++;
         $display("FAIL write_hit got hit=%b txns=%0d want 1/0", h, nRd + nWr); end
      total++; if (cpu_rdata !== 32'h2222_2222) begin bad++;
         $display("FAIL rdata_hold got=%h want=22222222", cpu_rdata); end
      doReq(1'b0, 10'h008, 32'h0, 0, h, rd, c);
      total++; if (h !== 1'b1 || rd !== 32'hDEAD_BEEF || nRd + nWr !== 0) begin bad++;
         $display("FAIL read_after_write got hit=%b rdata=%h txns=%0d want 1/deadbeef/0", h, rd, nRd + nWr); end
   endtask

   task automatic test_clean_evict();
      logic h; logic [31:0] rd; int c;
      doReq(1'b0, 10'h000, 32'h0, 0, h, rd, c);
      doReq(1'b0, 10'h020, 32'h0, 0, h, rd, c);
      total++; if (h !== 1'b0 || rd !== 32'h1111_1131) begin bad++;
         $display("FAIL fill_way1 got hit=%b rdata=%h want 0/11111131", h, rd); end
      doReq(1'b0, 10'h000, 32'h0, 0, h, rd, c);
      total++; if (h !== 1'b1 || rd !== 32'h1111_1111) begin bad++;
         $display("FAIL reuse_way0 got hit=%b rdata=%h want 1/11111111", h, rd); end
      doReq(1'b0, 10'h040, 32'h0, 0, h, rd, c);
      total++; if (nWr !== 0 || nRd !== 1 || lastRdAddr !== 10'h040) begin bad++;
         $display("FAIL clean_evict got wr=%0d rd=%0d addr=%h want 0/1/040", nWr, nRd, lastRdAddr); end
      total++; if (h !== 1'b0 || rd !== 32'h1111_1151) begin bad++;
         $display("FAIL clean_resp got hit=%b rdata=%h want 0/11111151", h, rd); end
   endtask

   task automatic test_dirty_evict();
      logic h; logic [31:0] rd; int c;
      doReq(1'b1, 10'h000, 32'hCAFE_F00D, 0, h, rd, c);
      total++; if (h !== 1'b1) begin bad++;
         $display("FAIL dirty_write got hit=%b want 1", h); end
      doReq(1'b0, 10'h020, 32'h0, 0, h, rd, c);
      total++; if (nWr !== 0 || nRd !== 1 || h !== 1'b0) begin bad++;
         $display("FAIL evict_clean_way got wr=%0d rd=%0d hit=%b want 0/1/0", nWr, nRd, h); end
      doReq(1'b0, 10'h040, 32'h0, 5, h, rd, c);
      total++; if (nWr !== 1 || firstRw !== 1'b1 || lastWrAddr !== 10'h000) begin bad++;
         $display("FAIL wb_txn got wr=%0d first=%b addr=%h want 1/1/000", nWr, firstRw, lastWrAddr); end
      total++; if (lastWrData !== 128'h44444444_DEADBEEF_22222222_CAFEF00D) begin bad++;
         $display("FAIL wb_data got=%h want=44444444deadbeef22222222cafef00d", lastWrData); end
      total++; if (nRd !== 1 || lastRdAddr !== 10'h040) begin bad++;
         $display("FAIL wb_refill got rd=%0d addr=%h want 1/040", nRd, lastRdAddr); end
      total++; if (stableBad !== 1'b0) begin bad++;
         $display("FAIL mem_stable got=%b want=0 (mem outputs moved while waiting for ack)", stableBad); end
      total++; if (h !== 1'b0 || rd !== 32'h1111_1151) begin bad++;
         $display("FAIL wb_resp got hit=%b rdata=%h want 0/11111151", h, rd); end
   endtask

   task automatic test_set1();
      logic h; logic [31:0] rd; int c;
      doReq(1'b0, 10'h01C, 32'h0, 1, h, rd, c);
      total++; if (nRd !== 1 || lastRdAddr !== 10'h010 || h !== 1'b0 || rd !== 32'h4444_4454) begin bad++;
         $display("FAIL set1 got rd=%0d addr=%h hit=%b rdata=%h want 1/010/0/44444454", nRd, lastRdAddr, h, rd); end
   endtask

   task automatic test_counters();
      total++; if (hit_cnt !== 16'd6 || miss_cnt !== 16'd6) begin bad++;
         $display("FAIL counters got=%0d/%0d want=6/6", hit_cnt, miss_cnt); end
   endtask

   task automatic test_reset_mid();
      logic h; logic [31:0] rd; int c; int k;
      @(negedge clk);
      cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 10'h060;
      @(negedge clk);
      cpu_req = 1'b0;
      k = 0;
      while (!mem_req && k < 20) begin @(negedge clk); k++; end
      total++; if (mem_req !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 10'h060) begin bad++;
         $display("FAIL pre_reset_refill got req=%b rw=%b addr=%h want 1/0/060", mem_req, mem_rw, mem_addr); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin bad++;
         $display("FAIL reset_abort got req=%b ready=%b want 0/0", mem_req, cpu_ready); end
      mem_rdata = '1; mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      total++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin bad++;
         $display("FAIL stray_ack got req=%b ready=%b cnt=%0d/%0d want 0/0/0/0", mem_req, cpu_ready, hit_cnt, miss_cnt); end
      doReq(1'b0, 10'h000, 32'h0, 0, h, rd, c);
      total++; if (h !== 1'b0 || nRd !== 1 || rd !== 32'h1111_1111) begin bad++;
         $display("FAIL post_reset_miss got hit=%b rd=%0d rdata=%h want 0/1/11111111", h, nRd, rd); end
      total++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin bad++;
         $display("FAIL post_reset_cnt got=%0d/%0d want=0/1", hit_cnt, miss_cnt); end
   endtask

   initial begin
      test_reset();
      test_refill_read();
      test_write_hit();
      test_clean_evict();
      test_dirty_evict();
      test_set1();
      test_counters();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
